// File: rtl/uart_pkg.sv
// Shared UART constants: data width, default Rx buffer depth and the Rx entry layout.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_RX_DEPTH    = 16;
    // A buffer entry is {ferr, data}; the framing flag sits just above the data bits.
    localparam int UART_RX_FERR_BIT = UART_DATA_W;
    localparam int UART_RX_ENTRY_W  = UART_DATA_W + 1;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Rx buffer bus: push side from the Rx FSM, pop/status side toward the core load/store path.
interface uart_rx_buffer_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_RX_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] rx_data_i;
    logic              rx_stop_i;
    logic              rx_valid_i;
    logic              rd_en_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_ferr_o;
    logic              rd_valid_o;
    logic              full_o;
    logic [CNT_W-1:0]  count_o;
    logic              overrun_o;
    logic              clr_overrun_i;
    logic              irq_o;

    modport slave (
        input  rx_data_i, rx_stop_i, rx_valid_i, rd_en_i, clr_overrun_i,
        output rd_data_o, rd_ferr_o, rd_valid_o, full_o, count_o, overrun_o, irq_o
    );

    modport master (
        output rx_data_i, rx_stop_i, rx_valid_i, rd_en_i, clr_overrun_i,
        input  rd_data_o, rd_ferr_o, rd_valid_o, full_o, count_o, overrun_o, irq_o
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x W register array, one synchronous write port and one asynchronous read port; not reset.
module uart_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART Rx byte buffer: FWFT FIFO of {ferr, data} entries with sticky overrun.
// Optional receive interrupt is built only when UART_RX_IRQ_EN is defined.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH         = UART_RX_DEPTH,
    parameter int DATA_W        = UART_DATA_W,
    parameter int IRQ_THRESHOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_buffer_if.slave   bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int EW    = DATA_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("uart_rx_buffer: DEPTH must be a power of 2 and >= 2");
    end
    if (IRQ_THRESHOLD < 1 || IRQ_THRESHOLD > DEPTH) begin : g_bad_thr
        $error("uart_rx_buffer: IRQ_THRESHOLD must be within 1..DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] count;
    logic             overrun_q, overrun_d;
    logic             empty, full, push, pop, drop;
    logic [EW-1:0]    head;

    // Extra pointer MSB makes the plain difference cover 0..DEPTH.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign pop  = bus.rd_en_i & ~empty;
    assign push = bus.rx_valid_i & (~full | pop);
    assign drop = bus.rx_valid_i & full & ~pop;

    assign wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    assign overrun_d = drop | (overrun_q & ~bus.clr_overrun_i);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({~bus.rx_stop_i, bus.rx_data_i}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (head)
    );

    assign bus.rd_data_o  = empty ? '0 : head[DATA_W-1:0];
    assign bus.rd_ferr_o  = ~empty & head[DATA_W];
    assign bus.rd_valid_o = ~empty;
    assign bus.full_o     = full;
    assign bus.count_o    = count;
    assign bus.overrun_o  = overrun_q;

`ifdef UART_RX_IRQ_EN
    localparam logic [PTR_W-1:0] THR_C = PTR_W'(IRQ_THRESHOLD);

    logic [PTR_W-1:0] count_d;
    logic             irq_q, irq_d;

    assign count_d = wr_ptr_d - rd_ptr_d;
    assign irq_d   = (count_d >= THR_C) | overrun_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq_o = irq_q;
`else
    assign bus.irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: queue-based model checked every cycle plus literal spot checks.
module tb_uart_rx_buffer;

    localparam int DEPTH = 16;
    localparam int THR   = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_rx_buffer_if #(.DATA_W(8), .DEPTH(DEPTH)) bus ();

    uart_rx_buffer #(
        .DEPTH         (DEPTH),
        .DATA_W        (8),
        .IRQ_THRESHOLD (THR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: a queue of {ferr, data} plus the sticky overrun and the interrupt it implies.
    logic [8:0] mq[$];
    logic       m_ovr = 1'b0;
    logic       m_irq = 1'b0;
    logic       m_drop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ovr = 1'b0;
            m_irq = 1'b0;
        end else begin
            m_drop = 1'b0;
            if (bus.rd_en_i && mq.size() > 0) void'(mq.pop_front());
            if (bus.rx_valid_i) begin
                if (mq.size() < DEPTH) mq.push_back({~bus.rx_stop_i, bus.rx_data_i});
                else m_drop = 1'b1;
            end
            if (m_drop) m_ovr = 1'b1;
            else if (bus.clr_overrun_i) m_ovr = 1'b0;
`ifdef UART_RX_IRQ_EN
            m_irq = (mq.size() >= THR) || m_ovr;
`else
            m_irq = 1'b0;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0] hd;
        hd = (mq.size() > 0) ? mq[0] : 9'h0;
        chk("m_valid", 32'(bus.rd_valid_o), 32'(mq.size() > 0));
        chk("m_data",  32'(bus.rd_data_o),  32'(hd[7:0]));
        chk("m_ferr",  32'(bus.rd_ferr_o),  32'(hd[8]));
        chk("m_count", 32'(bus.count_o),    32'(mq.size()));
        chk("m_full",  32'(bus.full_o),     32'(mq.size() == DEPTH));
        chk("m_ovr",   32'(bus.overrun_o),  32'(m_ovr));
        chk("m_irq",   32'(bus.irq_o),      32'(m_irq));
    end

    // One clock of stimulus; returns 1 time unit after the edge with inputs idle.
    task automatic step(input logic wr, input logic [7:0] d, input logic stop,
                        input logic rd, input logic clr);
        bus.rx_valid_i    = wr;
        bus.rx_data_i     = d;
        bus.rx_stop_i     = stop;
        bus.rd_en_i       = rd;
        bus.clr_overrun_i = clr;
        @(posedge clk);
        #1;
        bus.rx_valid_i    = 1'b0;
        bus.rx_data_i     = 8'h00;
        bus.rx_stop_i     = 1'b1;
        bus.rd_en_i       = 1'b0;
        bus.clr_overrun_i = 1'b0;
    endtask

    initial begin
        bus.rx_valid_i    = 1'b0;
        bus.rx_data_i     = 8'h00;
        bus.rx_stop_i     = 1'b1;
        bus.rd_en_i       = 1'b0;
        bus.clr_overrun_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count_o), 0);
        chk("rst_valid", 32'(bus.rd_valid_o), 0);
        chk("rst_full",  32'(bus.full_o), 0);
        rst = 1'b1;
        step(0, 8'h00, 1, 0, 0);

        // Asynchronous reset in the middle of a fill
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 1, 0, 0);
        chk("fill5_count", 32'(bus.count_o), 5);
        rst = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count_o), 0);
        chk("arst_valid", 32'(bus.rd_valid_o), 0);
        chk("arst_ovr",   32'(bus.overrun_o), 0);
        chk("arst_irq",   32'(bus.irq_o), 0);
        chk("arst_data",  32'(bus.rd_data_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 8'h00, 1, 0, 0);

        // Single byte, then pop back to empty
        step(1, 8'hA5, 1, 0, 0);
        chk("one_valid", 32'(bus.rd_valid_o), 1);
        chk("one_data",  32'(bus.rd_data_o), 32'h A5);
        chk("one_ferr",  32'(bus.rd_ferr_o), 0);
        chk("one_count", 32'(bus.count_o), 1);
        step(0, 8'h00, 1, 1, 0);
        chk("pop_valid", 32'(bus.rd_valid_o), 0);
        chk("pop_data",  32'(bus.rd_data_o), 0);
        step(0, 8'h00, 1, 1, 0);
        chk("empty_pop_count", 32'(bus.count_o), 0);

        // Fill to full, drain in order
        for (int i = 0; i < 16; i++) step(1, 8'(i), 1, 0, 0);
        chk("full_flag",  32'(bus.full_o), 1);
        chk("full_count", 32'(bus.count_o), 16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(bus.rd_data_o), 32'(i));
            step(0, 8'h00, 1, 1, 0);
        end
        chk("drain_empty", 32'(bus.rd_valid_o), 0);

        // Overrun: drop while full, set beats clear, then clear alone
        for (int i = 0; i < 16; i++) step(1, 8'(i), 1, 0, 0);
        step(1, 8'h55, 1, 0, 0);
        chk("ovr_set",   32'(bus.overrun_o), 1);
        chk("ovr_head",  32'(bus.rd_data_o), 32'h00);
        chk("ovr_count", 32'(bus.count_o), 16);
        step(1, 8'h66, 1, 0, 1);
        chk("ovr_set_wins", 32'(bus.overrun_o), 1);
        step(0, 8'h00, 1, 0, 1);
        chk("ovr_clr", 32'(bus.overrun_o), 0);

        // Full with simultaneous push and pop
        step(1, 8'h77, 1, 1, 0);
        chk("pp_count", 32'(bus.count_o), 16);
        chk("pp_ovr",   32'(bus.overrun_o), 0);
        chk("pp_head",  32'(bus.rd_data_o), 32'h01);
        for (int i = 1; i < 16; i++) begin
            chk("pp_order", 32'(bus.rd_data_o), 32'(i));
            step(0, 8'h00, 1, 1, 0);
        end
        chk("pp_last", 32'(bus.rd_data_o), 32'h77);
        step(0, 8'h00, 1, 1, 0);
        chk("pp_empty", 32'(bus.count_o), 0);

        // Push/pop pairs across pointer wrap
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h80 + i), 1, 0, 0);
            chk("wrap_data", 32'(bus.rd_data_o), 32'(8'h80 + i));
            step(0, 8'h00, 1, 1, 0);
        end

        // Framing error entry and interrupt threshold
        step(1, 8'h3C, 0, 0, 0);
        chk("ferr_set",  32'(bus.rd_ferr_o), 1);
        chk("ferr_data", 32'(bus.rd_data_o), 32'h3C);
        step(1, 8'h41, 1, 0, 0);
        step(1, 8'h42, 1, 0, 0);
        chk("irq_below", 32'(bus.irq_o), 0);
        step(1, 8'h43, 1, 0, 0);
`ifdef UART_RX_IRQ_EN
        chk("irq_at_thr", 32'(bus.irq_o), 1);
`else
        chk("irq_off", 32'(bus.irq_o), 0);
`endif
        step(0, 8'h00, 1, 1, 0);
        chk("irq_drop",   32'(bus.irq_o), 0);
        chk("ferr_next",  32'(bus.rd_ferr_o), 0);
        chk("head_next",  32'(bus.rd_data_o), 32'h41);
        repeat (4) step(0, 8'h00, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
